// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
package ifu_pkg;

    // Fetch sequencer states.
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        WAIT = 3'd2,
        HOLD = 3'd3,
        DROP = 3'd4
    } ifu_state_e;

    // Instruction word presented alongside a fetch fault.
    localparam logic [31:0] FETCH_FAULT_INST = 32'h0000_0000;

    // True when the PC is not on a 32-bit word boundary.
    function automatic logic is_misaligned(input logic [31:0] pc);
        return (pc[1:0] != 2'b00);
    endfunction

endpackage

// File: rtl/ifu_wdt.sv
// Response watchdog: counts cycles spent waiting for a memory response.
module ifu_wdt #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expire_c
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_EXP = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] r_count;

    // Saturating counter, cleared when a new request is accepted.
    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_count <= '0;
        end else if (i_enable && (r_count != CNT_MAX)) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    // Last waiting cycle before the fetch is declared lost.
    assign o_expire_c = (r_count == CNT_EXP);

endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: one memory read per core PC, buffered and handed
// to the core over a valid/ready handshake, with flush, misalignment and timeout.
module ifu_fetch
    import ifu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_i,
    input  logic        pc_valid_i,
    input  logic        flush_i,
    output logic        mem_req_valid_o,
    output logic [31:0] mem_req_addr_o,
    input  logic        mem_req_ready_i,
    input  logic        mem_rsp_valid_i,
    input  logic [31:0] mem_rsp_data_i,
    input  logic        mem_rsp_err_i,
    output logic        inst_valid_o,
    input  logic        inst_ready_i,
    output logic [31:0] inst_o,
    output logic [31:0] inst_pc_o,
    output logic        inst_err_o
);

    ifu_state_e  r_state;
    logic        r_req_valid;
    logic [31:0] r_addr;
    logic        r_inst_valid;
    logic [31:0] r_inst;
    logic [31:0] r_inst_pc;
    logic        r_inst_err;

    logic        w_accept;
    logic        w_req_hs;
    logic        w_wait;
    logic        w_expire;

    assign w_accept = r_inst_valid & inst_ready_i & ~flush_i;
    assign w_req_hs = (r_state == REQ) & mem_req_ready_i;
    assign w_wait   = (r_state == WAIT);

    ifu_wdt #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_wdt (
        .clk        (clk),
        .rst        (rst),
        .i_clear    (w_req_hs),
        .i_enable   (w_wait),
        .o_expire_c (w_expire)
    );

    // Fetch sequencer with its request, address and instruction buffers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_req_valid  <= 1'b0;
            r_addr       <= 32'h0;
            r_inst_valid <= 1'b0;
            r_inst       <= 32'h0;
            r_inst_pc    <= 32'h0;
            r_inst_err   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (!flush_i && pc_valid_i) begin
                        if (is_misaligned(pc_i)) begin
                            r_inst_pc    <= pc_i;
                            r_inst       <= FETCH_FAULT_INST;
                            r_inst_err   <= 1'b1;
                            r_inst_valid <= 1'b1;
                            r_state      <= HOLD;
                        end else begin
                            r_addr      <= pc_i;
                            r_req_valid <= 1'b1;
                            r_state     <= REQ;
                        end
                    end
                end
                REQ: begin
                    if (flush_i) begin
                        // An accepted request still owes a response that must be absorbed.
                        r_req_valid <= 1'b0;
                        r_state     <= mem_req_ready_i ? DROP : IDLE;
                    end else if (mem_req_ready_i) begin
                        r_req_valid <= 1'b0;
                        r_state     <= WAIT;
                    end
                end
                WAIT: begin
                    if (flush_i) begin
                        r_state <= mem_rsp_valid_i ? IDLE : DROP;
                    end else if (mem_rsp_valid_i) begin
                        r_inst_pc    <= r_addr;
                        r_inst       <= mem_rsp_err_i ? FETCH_FAULT_INST : mem_rsp_data_i;
                        r_inst_err   <= mem_rsp_err_i;
                        r_inst_valid <= 1'b1;
                        r_state      <= HOLD;
                    end else if (w_expire) begin
                        r_inst_pc    <= r_addr;
                        r_inst       <= FETCH_FAULT_INST;
                        r_inst_err   <= 1'b1;
                        r_inst_valid <= 1'b1;
                        r_state      <= HOLD;
                    end
                end
                HOLD: begin
                    if (flush_i || w_accept) begin
                        r_inst_valid <= 1'b0;
                        r_state      <= IDLE;
                    end
                end
                DROP: begin
                    if (mem_rsp_valid_i) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign mem_req_valid_o = r_req_valid;
    assign mem_req_addr_o  = r_addr;
    assign inst_valid_o    = r_inst_valid;
    assign inst_o          = r_inst;
    assign inst_pc_o       = r_inst_pc;
    assign inst_err_o      = r_inst_err;

endmodule
